// File: rtl/mul32x32_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul32x32_seq_ctrl
// Function : Sequential A x B multiply built from a combinational A x 8 stage,
//            one byte slice of B per cycle. Optional macro MUL_ZERO_SKIP_EN
//            ends the run early once the remaining B slices are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module mul32x32_seq_ctrl #(
    parameter int A_W    = 32,
    parameter int SLICES = 4,
    localparam int B_W   = 8 * SLICES,
    localparam int RES_W = A_W + B_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic [A_W-1:0]   mul_a,
    output logic [7:0]       mul_b,
    input  logic [A_W+7:0]   mul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic             busy
);

    localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [B_W-1:0]   b_reg;
    logic [RES_W-1:0] acc;
    logic [KW-1:0]    k;
    logic [7:0]       next_slice;
    logic             run_last;

    // Slice k+1 of B; mul_b is loaded one edge ahead so mul_y is valid in-cycle.
    assign next_slice = 8'(b_reg >> (8 * (32'(k) + 32'd1)));

`ifdef MUL_ZERO_SKIP_EN
    logic upper_zero;
    assign upper_zero = ((b_reg >> (8 * (32'(k) + 32'd1))) == '0);
    assign run_last   = (k == K_LAST) || upper_zero;
`else
    assign run_last   = (k == K_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            mul_a <= '0;
            mul_b <= '0;
            b_reg <= '0;
            acc   <= '0;
            k     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mul_a <= in_a;
                        b_reg <= in_b;
                        mul_b <= in_b[7:0];
                        acc   <= '0;
                        k     <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc + (RES_W'(mul_y) << {k, 3'b000});
                    if (run_last) begin
                        mul_b <= '0;
                        state <= S_DONE;
                    end else begin
                        mul_b <= next_slice;
                        k     <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign out_data  = acc;

endmodule
`default_nettype wire
